efuse_read_ctrl: RTL and testbench
==================================

// Module: efuse_read_ctrl
// PURPOSE
//  Parametrised eFuse read sequencer. Reads one NR-bit window (BPW = NR/DW words) from the eFuse macro.
//  Each window word is one DW-bit eFuse location. The sequencer drives eFuse rden/aen/addr under
//  programmable setup/access/gap timing, with optional per-window XOR checksum, abort and range check.
//  Sits between the digital config loader (start/sel/done) and the eFuse macro pins.
//  Next generation of the fixed 64-bit/8-bit reader.
// PARAMETERS
//  NR       64   window width in bits; must be a multiple of DW
//  DW       8    eFuse data word width in bits
//  AW       8    eFuse address width
//  NWIN     4    number of windows in the macro; window k covers addr k*BPW .. k*BPW+BPW-1
//  TW       6    width of each timing field
//  CHK_EN   1    1: XOR of all BPW words of a window must equal 0, else read_err
// PORTS
//  clk             in   1              read clock
//  rst_n           in   1              async reset, active low
//  rg_tsu          in   TW             rden-high to first aen-high, in cycles (minus 1)
//  rg_trd          in   TW             aen-high pulse length, in cycles (minus 1)
//  rg_tgap         in   TW             aen-low gap between words, in cycles (minus 1)
//  read_sel        in   $clog2(NWIN)+1 window index
//  read_start      in   1              start request; acted on only in IDLE
//  read_abort      in   1              abort the current read
//  read_done       out  1              sticky; set at end of read or abort; cleared by next accepted start
//  read_err        out  1              sticky; set on abort, bad sel or checksum fail; cleared by accepted start
//  busy_read       out  1              high in every state except IDLE
//  read_data       out  NR             assembled window; first word read lands in the MSBs
//  efuse_pgmen_o   out  1              tied 0
//  efuse_rden_o    out  1              read enable to macro
//  efuse_aen_o     out  1              access strobe to macro
//  efuse_addr_o    out  AW             word address to macro
//  efuse_rdata     in   DW             macro read data
// BEHAVIOUR
//  Reset state: FSM in IDLE. All outputs 0. Counters 0.
//  FSM states: IDLE, SETUP, AEN_HI, AEN_LO, TAIL.
//  - IDLE: read_start=1 with read_sel<NWIN
//      -> SETUP on the next edge. Clears read_done/read_err/read_data.
//      -> Loads addr = read_sel*BPW and sets rden=1.
//  - IDLE: read_start=1 with read_sel>=NWIN
//      -> stay in IDLE. read_done=1 and read_err=1 on the next edge. No eFuse activity.
//  - IDLE: read_start while busy is ignored.
//  - SETUP: lasts rg_tsu+1 cycles, then AEN_HI.
//  - AEN_HI: aen=1 for rg_trd+1 cycles.
//      On the last cycle (cnt==rg_trd) read_data <= {read_data[NR-DW-1:0], efuse_rdata}
//      and the checksum accumulator ^= efuse_rdata.
//      Exit to AEN_LO, or to TAIL if this was word BPW-1.
//  - AEN_LO: aen=0 for rg_tgap+1 cycles. addr increments by 1 on entry. Then AEN_HI.
//      addr is stable for the whole aen-high pulse.
//  - TAIL: rden=1, aen=0 for rg_tgap+1 cycles, then IDLE.
//      On the exit edge: rden=0, busy_read=0, read_done=1,
//      and read_err = CHK_EN & (accumulator != 0).
//  - Latency: read_done rises N edges after the start edge, where
//      N = (rg_tsu+1) + BPW*(rg_trd+rg_tgap+2).
//  - read_abort in any non-IDLE state:
//      next edge -> IDLE; rden=aen=0; read_done=1; read_err=1; read_data keeps the partial value.
//  - read_abort in IDLE has no effect.
//  - read_abort and read_start in the same cycle while busy: abort wins.
//  - rg_* changes mid-read: the new value applies from the next counter compare; not protected.
//  - A timing field of 0 gives a 1-cycle phase.
//  - Phase counter width is TW. It clears on every state change and never wraps within a phase.
//  - Word counter width is $clog2(BPW).
//  - addr does not wrap: the last word is NWIN*BPW-1, which is <= 2^AW-1 by constraint.
//  - Async reset mid-read: immediate return to IDLE with reset values. The eFuse pins go low at once.
// TESTING
//  1. NR=64, sel=1, tsu=1, trd=3, tgap=2, macro returns addr-indexed bytes 0x08..0x0F with XOR=0
//     -> read_data=0x08090A0B0C0D0E0F; done at edge 58; err=0.
//  2. Same as 1 but byte 0x0C changed to 0x1C -> read_data updated, done=1, err=1.
//  3. sel=4 (NWIN=4) -> done=1 and err=1 one edge later; rden/aen never assert.
//  4. Abort at edge 20 of test 1 -> next edge IDLE; rden=aen=0; done=err=1; read_data holds 2 bytes.
//  5. Second start while busy -> ignored: addresses 8..15 only, single done.
//  6. tsu=trd=tgap=0 -> aen period 2 cycles; addr stable while aen=1; done at edge 17.

Source files
------------

// File: rtl/efuse_read_ctrl.sv
// eFuse read sequencer: drives rden/aen/addr to fetch one NR-bit window with programmable
// setup/access/gap timing, optional XOR checksum, abort and window-range check.
module efuse_read_ctrl #(
    parameter int unsigned NR     = 64,
    parameter int unsigned DW     = 8,
    parameter int unsigned AW     = 8,
    parameter int unsigned NWIN   = 4,
    parameter int unsigned TW     = 6,
    parameter bit          CHK_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [TW-1:0]         rg_tsu,
    input  logic [TW-1:0]         rg_trd,
    input  logic [TW-1:0]         rg_tgap,
    input  logic [$clog2(NWIN):0] read_sel,
    input  logic                  read_start,
    input  logic                  read_abort,
    output logic                  read_done,
    output logic                  read_err,
    output logic                  busy_read,
    output logic [NR-1:0]         read_data,
    output logic                  efuse_pgmen_o,
    output logic                  efuse_rden_o,
    output logic                  efuse_aen_o,
    output logic [AW-1:0]         efuse_addr_o,
    input  logic [DW-1:0]         efuse_rdata
);
    localparam int unsigned BPW = NR / DW;
    localparam int unsigned WCW = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StAenHi,
        StAenLo,
        StTail
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic [WCW-1:0]  wcnt_q, wcnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [NR-1:0]   data_q, data_d;
    logic [DW-1:0]   acc_q, acc_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            rden_q, rden_d;
    logic            aen_q, aen_d;

    logic            sel_ok;
    logic [AW-1:0]   sel_addr;
    logic [NR-1:0]   data_shift;

    assign sel_ok   = (32'(read_sel) < NWIN);
    assign sel_addr = AW'(read_sel) * AW'(BPW);

    // First word read ends up in the MSBs after BPW shifts.
    if (BPW > 1) begin : g_shift
        assign data_shift = {data_q[NR-DW-1:0], efuse_rdata};
    end else begin : g_noshift
        assign data_shift = efuse_rdata;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + TW'(1);
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        acc_d   = acc_q;
        done_d  = done_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (read_start) begin
                    if (sel_ok) begin
                        state_d = StSetup;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        data_d  = '0;
                        acc_d   = '0;
                        wcnt_d  = '0;
                        addr_d  = sel_addr;
                    end else begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
                end
            end
            StSetup: begin
                if (cnt_q == rg_tsu) state_d = StAenHi;
            end
            StAenHi: begin
                if (cnt_q == rg_trd) begin
                    data_d = data_shift;
                    acc_d  = acc_q ^ efuse_rdata;
                    if (wcnt_q == WCW'(BPW - 1)) begin
                        state_d = StTail;
                    end else begin
                        state_d = StAenLo;
                        addr_d  = addr_q + AW'(1);
                        wcnt_d  = wcnt_q + WCW'(1);
                    end
                end
            end
            StAenLo: begin
                if (cnt_q == rg_tgap) state_d = StAenHi;
            end
            StTail: begin
                if (cnt_q == rg_tgap) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    err_d   = CHK_EN && (acc_q != '0);
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort overrides everything, including a capture on the same edge.
        if (read_abort && (state_q != StIdle)) begin
            state_d = StIdle;
            done_d  = 1'b1;
            err_d   = 1'b1;
            data_d  = data_q;
            acc_d   = acc_q;
            addr_d  = addr_q;
            wcnt_d  = wcnt_q;
        end

        if (state_d != state_q) cnt_d = '0;

        rden_d = (state_d != StIdle);
        aen_d  = (state_d == StAenHi);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            acc_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rden_q  <= 1'b0;
            aen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rden_q  <= rden_d;
            aen_q   <= aen_d;
        end
    end

    assign read_done     = done_q;
    assign read_err      = err_q;
    assign busy_read     = (state_q != StIdle);
    assign read_data     = data_q;
    assign efuse_pgmen_o = 1'b0;
    assign efuse_rden_o  = rden_q;
    assign efuse_aen_o   = aen_q;
    assign efuse_addr_o  = addr_q;

endmodule

// File: tb/tb_efuse_read_ctrl.sv
// Directed bench for efuse_read_ctrl: vector table of window reads plus hand sequences for
// abort in idle and asynchronous reset mid-read.
module tb_efuse_read_ctrl;
    localparam int unsigned NR   = 64;
    localparam int unsigned DW   = 8;
    localparam int unsigned AW   = 8;
    localparam int unsigned NWIN = 4;
    localparam int unsigned TW   = 6;
    localparam int unsigned SW   = $clog2(NWIN) + 1;
    localparam int unsigned BPW  = NR / DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [TW-1:0] rg_tsu = '0, rg_trd = '0, rg_tgap = '0;
    logic [SW-1:0] read_sel = '0;
    logic          read_start = 1'b0, read_abort = 1'b0;
    logic          read_done, read_err, busy_read;
    logic [NR-1:0] read_data;
    logic          efuse_pgmen_o, efuse_rden_o, efuse_aen_o;
    logic [AW-1:0] efuse_addr_o;
    logic [DW-1:0] efuse_rdata;

    logic [DW-1:0] mem [256];
    assign efuse_rdata = mem[efuse_addr_o];

    always #5 clk = ~clk;

    efuse_read_ctrl #(
        .NR(NR), .DW(DW), .AW(AW), .NWIN(NWIN), .TW(TW), .CHK_EN(1'b1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rg_tsu        (rg_tsu),
        .rg_trd        (rg_trd),
        .rg_tgap       (rg_tgap),
        .read_sel      (read_sel),
        .read_start    (read_start),
        .read_abort    (read_abort),
        .read_done     (read_done),
        .read_err      (read_err),
        .busy_read     (busy_read),
        .read_data     (read_data),
        .efuse_pgmen_o (efuse_pgmen_o),
        .efuse_rden_o  (efuse_rden_o),
        .efuse_aen_o   (efuse_aen_o),
        .efuse_addr_o  (efuse_addr_o),
        .efuse_rdata   (efuse_rdata)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [SW-1:0] sel;
        logic [TW-1:0] tsu;
        logic [TW-1:0] trd;
        logic [TW-1:0] tgap;
        bit            corrupt;
        int            abort_edge;
        int            restart_edge;
        logic [NR-1:0] exp_data;
        int            exp_edge;
        logic          exp_err;
        int            exp_aen;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input int idx, input vec_t v);
        int            done_edge = -1;
        int            aen_rises = 0;
        int            viol      = 0;
        logic          prev_aen  = 1'b0;
        logic [AW-1:0] prev_addr = '0;
        int            lo        = int'(v.sel) * int'(BPW);
        bit            ok_sel    = int'(v.sel) < int'(NWIN);
        string         tag       = $sformatf("v%0d", idx);

        if (v.corrupt) mem[12] = 8'h1C;
        rg_tsu     = v.tsu;
        rg_trd     = v.trd;
        rg_tgap    = v.tgap;
        read_sel   = v.sel;
        read_start = 1'b1;
        @(posedge clk);
        #1;
        read_start = 1'b0;
        check({tag, " busy_after_start"}, 64'(busy_read), 64'(ok_sel));

        for (int k = 1; k <= 300 && done_edge < 0; k++) begin
            if (k == v.abort_edge) read_abort = 1'b1;
            if (k == v.restart_edge) begin
                read_start = 1'b1;
                read_sel   = SW'(2);
            end
            @(posedge clk);
            #1;
            read_abort = 1'b0;
            read_start = 1'b0;
            read_sel   = v.sel;
            if (efuse_aen_o && !prev_aen) aen_rises++;
            if (efuse_aen_o && prev_aen && efuse_addr_o != prev_addr) viol++;
            if (efuse_rden_o && (!ok_sel || int'(efuse_addr_o) < lo ||
                                 int'(efuse_addr_o) > lo + int'(BPW) - 1)) viol++;
            prev_aen  = efuse_aen_o;
            prev_addr = efuse_addr_o;
            if (read_done) done_edge = k;
        end

        check({tag, " done_edge"}, 64'(done_edge), 64'(v.exp_edge));
        check({tag, " read_data"}, read_data, v.exp_data);
        check({tag, " read_err"}, 64'(read_err), 64'(v.exp_err));
        check({tag, " pins_low_at_done"}, 64'({efuse_rden_o, efuse_aen_o, busy_read}), 64'(0));
        check({tag, " aen_pulses"}, 64'(aen_rises), 64'(v.exp_aen));
        check({tag, " addr_violations"}, 64'(viol), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        check({tag, " idle_after_done"}, 64'({busy_read, efuse_rden_o, read_done}), 64'(1));
        mem[12] = 8'h0C;
    endtask

    initial begin
        logic [NR-1:0] held;

        for (int i = 0; i < 256; i++) mem[i] = DW'(i);

        //         sel    tsu    trd    tgap  cor  ab  rs  data                     edge err aen
        vecs[0] = '{3'd1, 6'd1, 6'd3, 6'd2, 1'b0, 0, 0, 64'h08090A0B0C0D0E0F, 58, 1'b0, 8};
        vecs[1] = '{3'd4, 6'd1, 6'd3, 6'd2, 1'b0, 0, 0, 64'h08090A0B0C0D0E0F, 1, 1'b1, 0};
        vecs[2] = '{3'd1, 6'd1, 6'd3, 6'd2, 1'b1, 0, 0, 64'h08090A0B1C0D0E0F, 58, 1'b1, 8};
        vecs[3] = '{3'd1, 6'd1, 6'd3, 6'd2, 1'b0, 20, 20, 64'h0000000000000809, 20, 1'b1, 3};
        vecs[4] = '{3'd1, 6'd1, 6'd3, 6'd2, 1'b0, 0, 10, 64'h08090A0B0C0D0E0F, 58, 1'b0, 8};
        vecs[5] = '{3'd0, 6'd0, 6'd0, 6'd0, 1'b0, 0, 0, 64'h0001020304050607, 17, 1'b0, 8};
        vecs[6] = '{3'd3, 6'd2, 6'd0, 6'd1, 1'b0, 0, 0, 64'h18191A1B1C1D1E1F, 27, 1'b0, 8};
        vecs[7] = '{3'd2, 6'd0, 6'd1, 6'd0, 1'b0, 0, 0, 64'h1011121314151617, 25, 1'b0, 8};

        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset done", 64'(read_done), 64'(0));
        check("reset err", 64'(read_err), 64'(0));
        check("reset busy", 64'(busy_read), 64'(0));
        check("reset data", read_data, 64'(0));
        check("reset pins", 64'({efuse_pgmen_o, efuse_rden_o, efuse_aen_o}), 64'(0));
        check("reset addr", 64'(efuse_addr_o), 64'(0));

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Abort while idle must leave the sticky results untouched.
        held       = read_data;
        read_abort = 1'b1;
        @(posedge clk);
        #1;
        read_abort = 1'b0;
        @(posedge clk);
        #1;
        check("idle_abort done_err", 64'({read_done, read_err}), 64'(2));
        check("idle_abort data", read_data, held);
        check("idle_abort busy", 64'(busy_read), 64'(0));

        // Asynchronous reset in the middle of a read.
        rg_tsu     = 6'd1;
        rg_trd     = 6'd3;
        rg_tgap    = 6'd2;
        read_sel   = 3'd1;
        read_start = 1'b1;
        @(posedge clk);
        #1;
        read_start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        check("pre_reset rden", 64'(efuse_rden_o), 64'(1));
        rst_n = 1'b0;
        #1;
        check("async_reset pins", 64'({efuse_rden_o, efuse_aen_o, busy_read}), 64'(0));
        check("async_reset flags", 64'({read_done, read_err}), 64'(0));
        check("async_reset data", read_data, 64'(0));
        check("async_reset addr", 64'(efuse_addr_o), 64'(0));
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        run_vec(8, vecs[5]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
